// File: rtl/bus_rr_scheduler.sv
// Round-robin scheduler sharing one enable-driven counter datapath among
// N_REQ requesters. A winner gets exactly len enable cycles; the final count
// is captured, returned with a done pulse, and compared against len.
module bus_rr_scheduler #(
   parameter int N_REQ     = 4,
   parameter int D_WIDTH   = 8,
   parameter int LEN_WIDTH = 4,
   parameter int ID_WIDTH  = $clog2(N_REQ)
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic [N_REQ-1:0]           req,
   input  logic [N_REQ*LEN_WIDTH-1:0] req_len,
   output logic [N_REQ-1:0]           gnt,
   output logic                       enable,
   input  logic [D_WIDTH-1:0]         data,
   output logic                       done,
   output logic [ID_WIDTH-1:0]        done_id,
   output logic [D_WIDTH-1:0]         result,
   output logic                       mismatch,
   output logic                       busy
);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      CAPTURE
   } state_t;

   state_t               state;
   logic [ID_WIDTH-1:0]  ptr;
   logic [LEN_WIDTH-1:0] cnt;
   logic [LEN_WIDTH-1:0] len;

   logic                 found;
   logic [ID_WIDTH-1:0]  win;
   logic [LEN_WIDTH-1:0] win_len;
   logic [ID_WIDTH-1:0]  win_next;

   // First requesting index at or above the pointer, wrapping around.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_len = '0;
      for (int unsigned k = 0; k < N_REQ; k++) begin
         int unsigned idx;
         idx = (32'(ptr) + k) % N_REQ;
         if (!found && req[idx]) begin
            found   = 1'b1;
            win     = ID_WIDTH'(idx);
            win_len = req_len[idx*LEN_WIDTH +: LEN_WIDTH];
         end
      end
      win_next = (win == ID_WIDTH'(N_REQ-1)) ? '0 : win + 1'b1;
   end

   // Arbitration, burst sequencing and result capture; every output registered.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         ptr      <= '0;
         cnt      <= '0;
         len      <= '0;
         gnt      <= '0;
         enable   <= 1'b0;
         done     <= 1'b0;
         done_id  <= '0;
         result   <= '0;
         mismatch <= 1'b0;
         busy     <= 1'b0;
      end else begin
         done     <= 1'b0;
         mismatch <= 1'b0;
         case (state)
            IDLE: begin
               // enable is low here, so the datapath clears on this edge and
               // every burst counts up from zero.
               if (found) begin
                  len     <= win_len;
                  gnt     <= N_REQ'(1) << win;
                  busy    <= 1'b1;
                  ptr     <= win_next;
                  done_id <= win;
                  if (win_len != '0) begin
                     enable <= 1'b1;
                     cnt    <= win_len;
                     state  <= RUN;
                  end else begin
                     state  <= CAPTURE;
                  end
               end
            end
            RUN: begin
               cnt <= cnt - 1'b1;
               if (cnt == LEN_WIDTH'(1)) begin
                  enable <= 1'b0;
                  state  <= CAPTURE;
               end
            end
            CAPTURE: begin
               // The datapath clears on this edge; data still holds the final count.
               result   <= data;
               done     <= 1'b1;
               mismatch <= (data != D_WIDTH'(len));
               gnt      <= '0;
               busy     <= 1'b0;
               state    <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_rr_scheduler.sv
// Bench for bus_rr_scheduler: table-driven vectors, directed corner
// sequences, then randomized traffic against a transaction-level model.
module tb_bus_rr_scheduler;

   localparam int N = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [3:0]  req = '0;
   logic [15:0] req_len = '0;
   logic [3:0]  gnt;
   logic        enable;
   logic [7:0]  data;
   logic        done;
   logic [1:0]  done_id;
   logic [7:0]  result;
   logic        mismatch;
   logic        busy;

   int errors = 0;
   int checks = 0;
   int skip_idx = -1;
   int en_idx = 0;

   bus_rr_scheduler #(.N_REQ(4), .D_WIDTH(8), .LEN_WIDTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .req_len(req_len), .gnt(gnt),
      .enable(enable), .data(data), .done(done), .done_id(done_id),
      .result(result), .mismatch(mismatch), .busy(busy)
   );

   always #5 clk = ~clk;

   // Counter datapath: clears when enable=0, increments when enable=1,
   // optionally skipping the increment on enabled edge number skip_idx.
   always @(posedge clk) begin
      if (!enable) begin
         data   <= '0;
         en_idx <= 0;
      end else begin
         en_idx <= en_idx + 1;
         if (en_idx != skip_idx) data <= data + 8'd1;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      req = '0;
      skip_idx = -1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Watch negedges until done (bounded); lat counts negedges since call.
   task automatic observe(input int maxc, output int lat, output int encnt,
                          output int gcnt, output logic [3:0] gfirst, output bit got);
      lat = 0; encnt = 0; gcnt = 0; gfirst = '0; got = 1'b0;
      while (!got && lat < maxc) begin
         @(negedge clk);
         lat++;
         if (lat == 1) gfirst = gnt;
         if (enable) encnt++;
         if (gnt != '0) gcnt++;
         if (done) got = 1'b1;
      end
   endtask

   typedef struct {
      logic [3:0]  req;
      logic [15:0] lens;
      int          id;
      int          len;
   } vec_t;

   typedef struct {
      int id;
      int len;
      int dedge;
   } txn_t;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      vec_t vt[6];
      int lat, encnt, gcnt;
      logic [3:0] gf;
      bit got;
      int order[5];

      vt[0] = '{4'b0001, 16'h0005, 0, 5};
      vt[1] = '{4'b0100, 16'h0000, 2, 0};
      vt[2] = '{4'b0010, 16'h00F0, 1, 15};
      vt[3] = '{4'b1111, 16'h3333, 2, 3};
      vt[4] = '{4'b0011, 16'h0071, 0, 1};
      vt[5] = '{4'b1001, 16'h7000, 3, 7};

      // Reset state
      #1;
      chk("rst_gnt", 32'(gnt), 0);
      chk("rst_enable", 32'(enable), 0);
      chk("rst_done", 32'(done), 0);
      chk("rst_done_id", 32'(done_id), 0);
      chk("rst_result", 32'(result), 0);
      chk("rst_mismatch", 32'(mismatch), 0);
      chk("rst_busy", 32'(busy), 0);
      do_reset();

      // Table-driven single transactions; pointer carries from one to the next
      for (int i = 0; i < 6; i++) begin
         req = vt[i].req;
         req_len = vt[i].lens;
         @(posedge clk);
         #1 req = '0;
         observe(40, lat, encnt, gcnt, gf, got);
         chk($sformatf("vec%0d_done", i), 32'(got), 1);
         chk($sformatf("vec%0d_gnt", i), 32'(gf), 32'(4'b0001 << vt[i].id));
         chk($sformatf("vec%0d_id", i), 32'(done_id), 32'(vt[i].id));
         chk($sformatf("vec%0d_result", i), 32'(result), 32'(vt[i].len));
         chk($sformatf("vec%0d_mismatch", i), 32'(mismatch), 0);
         chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].len + 2));
         chk($sformatf("vec%0d_encnt", i), 32'(encnt), 32'(vt[i].len));
         chk($sformatf("vec%0d_gntcnt", i), 32'(gcnt), 32'(vt[i].len + 1));
      end

      // Round-robin with all requests held: order 0,1,2,3,0 spaced 4 cycles
      do_reset();
      order = '{0, 1, 2, 3, 0};
      req = 4'b1111;
      req_len = 16'h2222;
      for (int i = 0; i < 5; i++) begin
         observe(20, lat, encnt, gcnt, gf, got);
         if (i == 4) req = '0;
         chk($sformatf("rr%0d_done", i), 32'(got), 1);
         chk($sformatf("rr%0d_id", i), 32'(done_id), 32'(order[i]));
         chk($sformatf("rr%0d_result", i), 32'(result), 2);
         chk($sformatf("rr%0d_spacing", i), 32'(lat), 4);
      end
      @(negedge clk);

      // Max length with a skipped increment: result 14, one-cycle mismatch
      do_reset();
      skip_idx = 4;
      req = 4'b0010;
      req_len = 16'h00F0;
      @(posedge clk);
      #1 req = '0;
      observe(40, lat, encnt, gcnt, gf, got);
      chk("skip_done", 32'(got), 1);
      chk("skip_encnt", 32'(encnt), 15);
      chk("skip_result", 32'(result), 14);
      chk("skip_mismatch", 32'(mismatch), 1);
      @(negedge clk);
      chk("skip_mismatch_pulse", 32'(mismatch), 0);
      chk("skip_done_pulse", 32'(done), 0);
      chk("skip_result_hold", 32'(result), 14);
      skip_idx = -1;

      // Reset in the middle of a burst
      do_reset();
      req = 4'b0100;
      req_len = 16'h0800;
      @(posedge clk);
      #1 req = '0;
      repeat (3) @(negedge clk);
      chk("midrst_enable_before", 32'(enable), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_enable", 32'(enable), 0);
      chk("midrst_gnt", 32'(gnt), 0);
      chk("midrst_busy", 32'(busy), 0);
      chk("midrst_done", 32'(done), 0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      observe(12, lat, encnt, gcnt, gf, got);
      chk("midrst_no_done", 32'(got), 0);
      req = 4'b1010;
      req_len = 16'h3030;
      @(posedge clk);
      #1 req = '0;
      observe(20, lat, encnt, gcnt, gf, got);
      chk("midrst_after_done", 32'(got), 1);
      chk("midrst_after_id", 32'(done_id), 1);
      chk("midrst_after_result", 32'(result), 3);
      chk("midrst_after_mismatch", 32'(mismatch), 0);

      // Drop req0 during its burst; req1 granted right after done
      do_reset();
      req = 4'b0011;
      req_len = 16'h0024;
      @(posedge clk);
      @(negedge clk);
      req = 4'b0010;
      observe(20, lat, encnt, gcnt, gf, got);
      chk("drop_done", 32'(got), 1);
      chk("drop_id", 32'(done_id), 0);
      chk("drop_result", 32'(result), 4);
      @(negedge clk);
      chk("drop_next_gnt", 32'(gnt), 32'(4'b0010));
      req = '0;
      observe(20, lat, encnt, gcnt, gf, got);
      chk("drop_next_done", 32'(got), 1);
      chk("drop_next_id", 32'(done_id), 1);
      chk("drop_next_result", 32'(result), 2);

      // Random traffic against a transaction-level model
      do_reset();
      begin
         int m_ptr, m_free, ren;
         txn_t q[$];
         m_ptr = 0; m_free = 0; ren = 0;
         for (int k = 0; k < 400; k++) begin
            req = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
            req_len = 16'($urandom);
            if (k >= m_free && req != 0) begin
               int w, l;
               w = -1;
               for (int j = 0; j < N; j++)
                  if (w < 0 && req[(m_ptr + j) % N]) w = (m_ptr + j) % N;
               l = int'((req_len >> (4 * w)) & 16'hF);
               q.push_back('{w, l, k + l + 1});
               m_free = k + l + 2;
               m_ptr = (w + 1) % N;
            end
            @(posedge clk);
            @(negedge clk);
            if (enable) ren++;
            if (q.size() > 0 && k < q[0].dedge) begin
               chk("rnd_gnt", 32'(gnt), 32'(4'b0001 << q[0].id));
               chk("rnd_busy", 32'(busy), 1);
            end else begin
               chk("rnd_gnt_idle", 32'(gnt), 0);
               chk("rnd_busy_idle", 32'(busy), 0);
            end
            if (q.size() > 0 && q[0].dedge == k) begin
               chk("rnd_done", 32'(done), 1);
               chk("rnd_id", 32'(done_id), 32'(q[0].id));
               chk("rnd_result", 32'(result), 32'(q[0].len));
               chk("rnd_mismatch", 32'(mismatch), 0);
               chk("rnd_encnt", 32'(ren), 32'(q[0].len));
               ren = 0;
               void'(q.pop_front());
            end else begin
               chk("rnd_no_done", 32'(done), 0);
            end
         end
      end
      req = '0;
      repeat (20) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
